// File: rtl/float24_to_fix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : float24_to_fix_pkg
// Description : Shared constants, state encoding and field helpers for the
//               24-bit custom float to fixed-point converter.
//               Float layout {s, e[6:0], m[15:0]}, exponent bias 63,
//               hidden leading 1, all-zero exponent encodes zero.
// Revision    : 1.0 - initial release
// ============================================================================
package float24_to_fix_pkg;

    localparam int C_EXP_W   = 7;
    localparam int C_MAN_W   = 16;
    localparam int C_BIAS    = 63;
    localparam int C_FLOAT_W = 24;

    // Converter control states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2,
        S_OUT    = 2'd3
    } state_t;

    // Field slices of a packed float operand
    function automatic logic f_sign(input logic [C_FLOAT_W-1:0] f);
        return f[C_FLOAT_W-1];
    endfunction

    function automatic logic [C_EXP_W-1:0] f_exp(input logic [C_FLOAT_W-1:0] f);
        return f[C_FLOAT_W-2 -: C_EXP_W];
    endfunction

    function automatic logic [C_MAN_W-1:0] f_man(input logic [C_FLOAT_W-1:0] f);
        return f[C_MAN_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/float24_to_fix_if.sv
`default_nettype none
// ============================================================================
// Module      : float24_to_fix_if
// Description : Operand/result handshake bundle of the float-to-fixed
//               converter. The converter uses the slave view, the float
//               core / serializer side uses the master view.
// Revision    : 1.0 - initial release
// ============================================================================
interface float24_to_fix_if
    import float24_to_fix_pkg::*;
#(
    parameter int OUT_W = 24
);
    logic [C_FLOAT_W-1:0] in_float;
    logic                 in_valid;
    logic                 in_ready;
    logic [OUT_W-1:0]     out_fix;
    logic                 out_sat;
    logic                 out_uflow;
    logic                 out_valid;
    logic                 out_ready;

    modport slave (
        input  in_float, in_valid, out_ready,
        output in_ready, out_fix, out_sat, out_uflow, out_valid
    );

    modport master (
        output in_float, in_valid, out_ready,
        input  in_ready, out_fix, out_sat, out_uflow, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/float24_to_fix_round_sat.sv
`default_nettype none
// ============================================================================
// Module      : fix_round_sat
// Description : Combinational back end of the converter: rounding, clamping
//               to the signed output range, sign application and flags.
//               Build option FIX_ROUND_EN selects round-half-away-from-zero;
//               without it the magnitude is truncated toward zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fix_round_sat #(
    parameter int OUT_W = 24,
    parameter int MAG_W = OUT_W + 2
) (
    input  wire logic [MAG_W-1:0] mag,
    input  wire logic             guard,
    input  wire logic             sticky,
    input  wire logic             sign,
    input  wire logic             is_zero,
    input  wire logic             force_sat,
    input  wire logic             force_uflow,
    output logic      [OUT_W-1:0] out_fix,
    output logic                  out_sat,
    output logic                  out_uflow
);
    // Magnitude limits: 2^(OUT_W-1)-1 for positive, 2^(OUT_W-1) for negative
    logic [MAG_W:0]   w_lim_pos;
    logic [MAG_W:0]   w_lim_neg;
    logic [MAG_W:0]   w_lim;
    logic [MAG_W:0]   w_rmag;
    logic [OUT_W-1:0] w_lo;
    logic             w_unused_bits;

    assign w_lim_neg = {{(MAG_W+1-OUT_W){1'b0}}, 1'b1, {(OUT_W-1){1'b0}}};
    assign w_lim_pos = {{(MAG_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    assign w_lim     = sign ? w_lim_neg : w_lim_pos;

`ifdef FIX_ROUND_EN
    // Ties go up in magnitude; the extra bit keeps a rounding carry visible
    // to the saturation compare.
    assign w_rmag        = {1'b0, mag} + {{MAG_W{1'b0}}, guard};
    assign w_unused_bits = sticky;
`else
    assign w_rmag        = {1'b0, mag};
    assign w_unused_bits = guard ^ sticky;
`endif

    assign w_lo = w_rmag[OUT_W-1:0];

    // Early-out flags take priority over the computed magnitude
    always_comb begin
        out_fix   = '0;
        out_sat   = 1'b0;
        out_uflow = 1'b0;
        if (is_zero) begin
            out_fix = '0;
        end else if (force_uflow) begin
            out_uflow = 1'b1;
        end else if (force_sat || (w_rmag > w_lim)) begin
            out_sat = 1'b1;
            out_fix = sign ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            out_fix   = sign ? -w_lo : w_lo;
            out_uflow = (w_rmag == '0);
        end
    end
endmodule
`default_nettype wire

// File: rtl/float24_to_fix.sv
`default_nettype none
// ============================================================================
// Module      : float24_to_fix
// Description : Iterative converter from the 24-bit custom float to signed
//               fixed point (OUT_W bits, FRAC_W fractional). One shift per
//               clock, valid/ready on both sides. Build option FIX_ROUND_EN
//               enables round-half-away-from-zero (default: truncation).
// Revision    : 1.0 - initial release
// ============================================================================
module float24_to_fix
    import float24_to_fix_pkg::*;
#(
    parameter int OUT_W  = 24,
    parameter int FRAC_W = 8
) (
    input wire logic       clk,
    input wire logic       rst,
    float24_to_fix_if.slave bus
);
    localparam int C_MAG_W = OUT_W + 2;
    localparam int C_SH_W  = 10;

    // Shift amount is e - C_SH_OFF; bounds select the early-out paths
    localparam logic signed [C_SH_W-1:0] C_SH_OFF = C_SH_W'(C_BIAS - FRAC_W + C_MAN_W);
    localparam logic signed [C_SH_W-1:0] C_SH_MAX = C_SH_W'(OUT_W - C_MAN_W);
    localparam logic signed [C_SH_W-1:0] C_SH_MIN = -C_SH_W'(C_MAN_W + 2);
    localparam logic        [C_SH_W-1:0] C_ONE    = C_SH_W'(1);

    state_t               r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [OUT_W-1:0]     r_out_fix;
    logic                 r_out_sat;
    logic                 r_out_uflow;
    logic [C_MAG_W-1:0]   r_mag;
    logic                 r_guard;
    logic                 r_sticky;
    logic [C_SH_W-1:0]    r_cnt;
    logic                 r_left;
    logic                 r_sign;
    logic                 r_zero;
    logic                 r_force_sat;
    logic                 r_force_uflow;

    logic [C_EXP_W-1:0]        w_exp;
    logic [C_MAN_W-1:0]        w_man;
    logic signed [C_SH_W-1:0]  w_sh;
    logic [C_SH_W-1:0]         w_sh_abs;
    logic                      w_is_zero;
    logic                      w_f_sat;
    logic                      w_f_uflow;
    logic [OUT_W-1:0]          w_fix;
    logic                      w_sat;
    logic                      w_uflow;

    assign w_exp     = f_exp(bus.in_float);
    assign w_man     = f_man(bus.in_float);
    assign w_sh      = $signed({{(C_SH_W-C_EXP_W){1'b0}}, w_exp}) - C_SH_OFF;
    assign w_sh_abs  = w_sh[C_SH_W-1] ? -w_sh : w_sh;
    assign w_is_zero = (w_exp == '0);
    assign w_f_sat   = !w_is_zero && (w_sh > C_SH_MAX);
    assign w_f_uflow = !w_is_zero && (w_sh < C_SH_MIN);

    fix_round_sat #(
        .OUT_W (OUT_W),
        .MAG_W (C_MAG_W)
    ) u_round_sat (
        .mag         (r_mag),
        .guard       (r_guard),
        .sticky      (r_sticky),
        .sign        (r_sign),
        .is_zero     (r_zero),
        .force_sat   (r_force_sat),
        .force_uflow (r_force_uflow),
        .out_fix     (w_fix),
        .out_sat     (w_sat),
        .out_uflow   (w_uflow)
    );

    // Control FSM, shift datapath and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_out_fix     <= '0;
            r_out_sat     <= 1'b0;
            r_out_uflow   <= 1'b0;
            r_mag         <= '0;
            r_guard       <= 1'b0;
            r_sticky      <= 1'b0;
            r_cnt         <= '0;
            r_left        <= 1'b0;
            r_sign        <= 1'b0;
            r_zero        <= 1'b0;
            r_force_sat   <= 1'b0;
            r_force_uflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_sign        <= f_sign(bus.in_float);
                        r_mag         <= {{(C_MAG_W-C_MAN_W-1){1'b0}}, 1'b1, w_man};
                        r_guard       <= 1'b0;
                        r_sticky      <= 1'b0;
                        r_zero        <= w_is_zero;
                        r_force_sat   <= w_f_sat;
                        r_force_uflow <= w_f_uflow;
                        r_left        <= !w_sh[C_SH_W-1];
                        r_cnt         <= w_sh_abs;
                        r_in_ready    <= 1'b0;
                        if (w_is_zero || w_f_sat || w_f_uflow || (w_sh == '0)) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (r_left) begin
                        r_mag <= {r_mag[C_MAG_W-2:0], 1'b0};
                    end else begin
                        r_mag    <= {1'b0, r_mag[C_MAG_W-1:1]};
                        r_guard  <= r_mag[0];
                        r_sticky <= r_sticky | r_guard;
                    end
                    r_cnt <= r_cnt - C_ONE;
                    if (r_cnt == C_ONE) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_out_fix   <= w_fix;
                    r_out_sat   <= w_sat;
                    r_out_uflow <= w_uflow;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_fix   = r_out_fix;
    assign bus.out_sat   = r_out_sat;
    assign bus.out_uflow = r_out_uflow;
endmodule
`default_nettype wire

// File: tb/tb_float24_to_fix.sv
`default_nettype none
// ============================================================================
// Module      : tb_float24_to_fix
// Description : Self-checking bench for float24_to_fix: directed boundary
//               cases, backpressure, mid-operation reset and random operands
//               checked against a real-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_float24_to_fix;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    float24_to_fix_if #(.OUT_W(24)) bus ();

    float24_to_fix #(
        .OUT_W  (24),
        .FRAC_W (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: value = (1 + m/2^16) * 2^(e-63), scaled by 2^8, then
    // rounded or truncated, clamped and signed.
    task automatic model(input logic [23:0] f, output logic [23:0] fx,
                         output logic sat, output logic uf, output int lat);
        int      e;
        int      m;
        int      sh;
        int      ash;
        logic    s;
        real     v;
        real     r;
        real     lim;
        longint  q;
        s   = f[23];
        e   = int'(f[22:16]);
        m   = int'(f[15:0]);
        sh  = e - 63 + 8 - 16;
        ash = (sh < 0) ? -sh : sh;
        fx  = 24'h0;
        sat = 1'b0;
        uf  = 1'b0;
        lat = (e == 0 || sh > 8 || sh < -18 || sh == 0) ? 2 : ash + 2;
        if (e != 0) begin
            v = 65536.0 + real'(m);
            for (int i = 0; i < ash; i++) v = (sh > 0) ? v * 2.0 : v / 2.0;
`ifdef FIX_ROUND_EN
            r = $floor(v + 0.5);
`else
            r = $floor(v);
`endif
            lim = s ? 8388608.0 : 8388607.0;
            if (r > lim) begin
                sat = 1'b1;
                fx  = s ? 24'h800000 : 24'h7FFFFF;
            end else begin
                q  = longint'(r);
                fx = s ? 24'(-q) : 24'(q);
                uf = (r == 0.0);
            end
        end
    endtask

    // One conversion; called just after a rising edge with the DUT in IDLE.
    task automatic do_conv(input logic [23:0] f, input int hold, input logic [23:0] efix,
                           input logic esat, input logic euf, input int elat);
        int cyc;
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_float  = f;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cyc = 1;
        while (bus.out_valid !== 1'b1 && cyc < 100) begin
            chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(elat));
        chk("out_fix", 32'(bus.out_fix), 32'(efix));
        chk("out_sat", 32'(bus.out_sat), 32'(esat));
        chk("out_uflow", 32'(bus.out_uflow), 32'(euf));
        for (int i = 0; i < hold; i++) begin
            bus.in_float = ~f;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_fix", 32'(bus.out_fix), 32'(efix));
            chk("hold_flags", 32'({bus.out_sat, bus.out_uflow}), 32'({esat, euf}));
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", 32'(bus.out_valid), 32'd0);
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic do_model_conv(input logic [23:0] f, input int hold);
        logic [23:0] fx;
        logic        sat;
        logic        uf;
        int          lat;
        model(f, fx, sat, uf, lat);
        do_conv(f, hold, fx, sat, uf, lat);
    endtask

    initial begin
        logic [23:0] f;
        rst           = 1'b1;
        bus.in_float  = 24'h0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_fix", 32'(bus.out_fix), 32'd0);
        chk("rst_flags", 32'({bus.out_sat, bus.out_uflow}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases with hand-derived results
        do_conv(24'h469040, 0, 24'h00C820, 1'b0, 1'b0, 3);
        do_conv(24'h3D8000, 0, 24'h000060, 1'b0, 1'b0, 12);
        do_conv(24'hC69040, 0, 24'hFF37E0, 1'b0, 1'b0, 3);
        do_conv(24'h7F0000, 0, 24'h7FFFFF, 1'b1, 1'b0, 2);
        do_conv(24'hFF0000, 0, 24'h800000, 1'b1, 1'b0, 2);
        do_conv(24'h000000, 0, 24'h000000, 1'b0, 1'b0, 2);
        do_conv(24'h800000, 0, 24'h000000, 1'b0, 1'b0, 2);
        do_conv(24'h350000, 0, 24'h000000, 1'b0, 1'b1, 20);
`ifdef FIX_ROUND_EN
        do_conv(24'h360000, 0, 24'h000001, 1'b0, 1'b0, 19);
`else
        do_conv(24'h360000, 0, 24'h000000, 1'b0, 1'b1, 19);
`endif
        do_conv(24'h470000, 0, 24'h010000, 1'b0, 1'b0, 2);
        do_conv(24'h4F0000, 0, 24'h7FFFFF, 1'b1, 1'b0, 10);
        do_conv(24'h4E0000, 0, 24'h7FFFFF, 1'b1, 1'b0, 9);
        do_conv(24'hCE0000, 0, 24'h800000, 1'b0, 1'b0, 9);
        do_conv(24'h469040, 5, 24'h00C820, 1'b0, 1'b0, 3);

        // Reset while shifting aborts the conversion
        bus.in_float  = 24'h3D8000;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_out_fix", 32'(bus.out_fix), 32'd0);
        chk("abort_flags", 32'({bus.out_sat, bus.out_uflow}), 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("abort_no_valid", 32'(bus.out_valid), 32'd0);
        end
        do_conv(24'h3D8000, 0, 24'h000060, 1'b0, 1'b0, 12);

        // Random operands, mostly in the interesting exponent window
        for (int n = 0; n < 40; n++) begin
            f[23]    = 1'($urandom_range(0, 1));
            f[22:16] = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127))
                                                   : 7'($urandom_range(44, 82));
            f[15:0]  = 16'($urandom);
            do_model_conv(f, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/float24_to_fix.md
Name: float24_to_fix

Overview:
- Converts the 24-bit custom float used by `top_level` into signed two's-complement fixed point, for the codec sample path.
- Float format: 1 sign bit, 7 exponent bits (bias 63), 16 mantissa bits with a hidden leading 1. All-zero exponent means zero.
- Multi-cycle iterative shifter with valid/ready handshakes on both sides. It sits between the float core's `float_out` and the codec serializer.

Parameters:
- OUT_W, 24, width of the signed fixed-point output.
- FRAC_W, 8, number of fractional bits in the output.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- in_float  input  24  float operand, format {s, e[6:0], m[15:0]}.
- in_valid  input  1  in_float is valid.
- in_ready  output  1  block can accept an operand.
- out_fix  output  OUT_W  signed fixed result, FRAC_W fractional bits.
- out_sat  output  1  result was clamped to the positive or negative limit.
- out_uflow  output  1  nonzero input produced a zero result.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_fix=0, out_sat=0, out_uflow=0.
- Reset mid-operation aborts the conversion; no result is produced.
- FSM states: IDLE, SHIFT, FINISH, OUT.
- IDLE:
  - in_ready=1. On in_valid, latch s, e and mag = {1,m} (17 bits, in an OUT_W+2-bit register).
  - Compute sh = e - 63 + FRAC_W - 16 (signed).
  - Go to SHIFT if sh != 0, else go to FINISH.
- Early outs (decided in IDLE, no shifting, go straight to FINISH):
  - e==0: result is 0, out_uflow=0.
  - sh > OUT_W-16: force saturation.
  - sh < -18: result is 0, out_uflow=1.
- SHIFT: one bit per cycle, |sh| cycles, driven by a down-counter.
  - Left shift when sh>0.
  - Right shift when sh<0: the bit shifted out goes to guard; the previous guard ORs into sticky.
- FINISH (1 cycle), then go to OUT:
  - Apply rounding on the magnitude (see Optional Feature).
  - Saturate: positive limit 2^(OUT_W-1)-1; negative magnitude limit 2^(OUT_W-1).
  - Negate if s=1, then register out_fix and the flags.
- OUT: out_valid=1; hold all outputs stable until out_ready. Then clear out_valid and go to IDLE.
- in_ready=0 in every state except IDLE. Accept-to-out_valid latency is |sh|+2 cycles.
- A negative zero input (s=1, e=0) gives out_fix=0.
- Saturation outputs: 0x7FFFFF for positive, 0x800000 for negative (OUT_W=24).
- out_sat and out_uflow are mutually exclusive.

Optional Feature:
- Macro: FIX_ROUND_EN.
- Defined: round half away from zero. Add guard to the magnitude (ties go up); sticky does not affect the decision. A carry out of rounding is re-checked for saturation.
- Undefined: truncate toward zero; guard and sticky are ignored. out_uflow is set whenever a nonzero input truncates to 0.

Decomposition:
- Header `float24_defs.vh` holds the shared constants: EXP_W=7, MAN_W=16, BIAS=63, FLOAT_W=24, and field-slice macros for sign, exponent and mantissa. The float core uses the same header.
- One natural combinational sub-module, `fix_round_sat`: takes magnitude, guard, sign and the early flags; outputs out_fix, out_sat and out_uflow.
- The FSM, shift register and counter stay in the top module.

Test Plan:
- in_float=0x469040 (200.125), out_ready=1 -> out_fix=0x00C820, flags 0, out_valid 3 cycles after accept.
- in_float=0x3D8000 (0.375) -> out_fix=0x000060 after 12 cycles. 0xC69040 (-200.125) -> 0xFF37E0.
- 0x7F0000 -> 0x7FFFFF with out_sat=1. 0xFF0000 -> 0x800000 with out_sat=1. 0x000000 and 0x800000 -> 0, no flags.
- 0x350000 (2^-10) -> 0 with out_uflow=1. 0x360000 (half LSB) -> 0x000001 with FIX_ROUND_EN, else 0 with out_uflow=1.
- Hold out_ready=0 for 5 cycles in OUT -> outputs stable, in_ready=0, a new in_valid is ignored. Then out_ready=1 -> IDLE next cycle.
- Assert rst during SHIFT of 0x3D8000 -> next cycle is IDLE with reset values and no out_valid; the following conversion is correct.
